// File: rtl/binary_to_bcd_pkg.sv
// Shared definitions for the double-dabble converter: FSM encoding and BCD digit width.
package binary_to_bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_add3
  import binary_to_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= DIGIT_W'(5)) ? i_digit + DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential binary->packed-BCD converter; N shift cycles, result valid N+1 cycles after accept.
// One conversion in flight: in_ready only in IDLE, DONE holds bcd/out_valid until out_ready.
module binary_to_bcd
  import binary_to_bcd_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N-1:0]         i_binary,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [DIGIT_W*D-1:0] o_bcd,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
);

  localparam int CW = $clog2(N + 1);
  localparam int BW = DIGIT_W * D;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [BW-1:0] r_bcd_sr;
  logic [BW-1:0] r_bcd;
  logic [BW-1:0] w_adj;
  logic [BW-1:0] w_bcd_shift;
  logic [N-1:0]  r_bin_sr;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_last_shift;

  if ((10 ** D) <= (2 ** N - 1)) begin : g_width_chk
    $error("binary_to_bcd: D=%0d digits cannot hold 2**%0d-1", D, N);
  end

  for (genvar k = 0; k < D; k++) begin : g_digit
    bcd_add3 u_add3 (
      .i_digit (r_bcd_sr[DIGIT_W*k +: DIGIT_W]),
      .o_digit (w_adj[DIGIT_W*k +: DIGIT_W])
    );
  end

  // Corrected digits shift left by one, pulling in the next binary MSB.
  assign w_bcd_shift = (w_adj << 1) | BW'(r_bin_sr[N-1]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    w_accept     = 1'b0;
    w_last_shift = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = ~i_reset;
        if (i_in_valid && !i_reset) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_last_shift = 1'b1;
          w_state_nxt  = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcd_sr <= '0;
      r_bin_sr <= '0;
      r_cnt    <= '0;
      r_bcd    <= '0;
    end else if (w_accept) begin
      r_bcd_sr <= '0;
      r_bin_sr <= i_binary;
      r_cnt    <= CW'(N);
    end else if (r_state == SHIFT) begin
      r_bcd_sr <= w_bcd_shift;
      r_bin_sr <= r_bin_sr << 1;
      r_cnt    <= r_cnt - CW'(1);
      if (w_last_shift) begin
        r_bcd <= w_bcd_shift;
      end
    end
  end

  assign o_bcd = r_bcd;

endmodule
